// File: rtl/tag_acq_ctrl.sv
// Acquisition sequencer for the pulse time-tagger. It runs IDLE/ARM/RUN/DRAIN
// and buffers tagged words in a first-word-fall-through FIFO for host readout.
module tag_acq_ctrl #(
  parameter int DEPTH = 16,
  parameter int RUN_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [RUN_W-1:0] run_rollovers_i,
  input  logic             tag_ready_i,
  input  logic [31:0]      tag_data_i,
  output logic             clear_o,
  output logic             operate_o,
  output logic             rd_valid_o,
  output logic [31:0]      rd_data_o,
  input  logic             rd_ack_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             overflow_o,
  output logic [31:0]      tag_count_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [RUN_W-1:0] limit_q, rollCnt_q, rollNext;
  logic [AW-1:0]    wrPtr_q, rdPtr_q;
  logic [AW:0]      count_q;
  logic [31:0]      mem_q [DEPTH];
  logic [31:0]      tagCount_q;
  logic             clear_q, operate_q, done_q, overflow_q, drainSeen_q;

  logic startAcc, capture, fifoEmpty, fifoFull, push, pop, drop;
  logic rollInc, limitHit;

  assign startAcc  = (state_q == IDLE) && start_i;
  assign capture   = (state_q == RUN) || (state_q == DRAIN);
  assign fifoEmpty = (count_q == '0);
  assign fifoFull  = (count_q == (AW+1)'(DEPTH));
  assign pop       = rd_ack_i && !fifoEmpty;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign push      = tag_ready_i && capture && (!fifoFull || pop);
  assign drop      = tag_ready_i && capture && fifoFull && !pop;
  assign rollInc   = push && (state_q == RUN) && tag_data_i[31];
  assign rollNext  = rollCnt_q + RUN_W'(1);
  assign limitHit  = rollInc && (limit_q != '0) && (rollNext == limit_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = ARM;
      ARM:     state_d = stop_i ? DRAIN : RUN;
      RUN:     if (stop_i || limitHit) state_d = DRAIN;
      DRAIN:   if (drainSeen_q && fifoEmpty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      clear_q     <= 1'b0;
      operate_q   <= 1'b0;
      done_q      <= 1'b0;
      drainSeen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clear_q     <= (state_d == ARM);
      operate_q   <= (state_d == RUN);
      done_q      <= (state_q == DRAIN) && (state_d == IDLE);
      drainSeen_q <= (state_q == DRAIN);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      limit_q    <= '0;
      rollCnt_q  <= '0;
      tagCount_q <= '0;
      overflow_q <= 1'b0;
    end else if (startAcc) begin
      limit_q    <= run_rollovers_i;
      rollCnt_q  <= '0;
      tagCount_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (rollInc) rollCnt_q <= rollNext;
      if (push && (tagCount_q != 32'hFFFF_FFFF)) tagCount_q <= tagCount_q + 32'd1;
      if (drop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + AW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; rd_data is masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wrPtr_q] <= tag_data_i;
  end

  assign clear_o     = clear_q;
  assign operate_o   = operate_q;
  assign done_o      = done_q;
  assign overflow_o  = overflow_q;
  assign tag_count_o = tagCount_q;
  assign busy_o      = (state_q != IDLE);
  assign rd_valid_o  = !fifoEmpty;
  assign rd_data_o   = fifoEmpty ? 32'd0 : mem_q[rdPtr_q];

endmodule

// File: tb/tb_tag_acq_ctrl.sv
// Directed bench for tag_acq_ctrl; expected words are queued when driven and
// compared when the host pops them.
module tb_tag_acq_ctrl;
  localparam int DEPTH = 16;
  localparam int RUN_W = 16;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             start_i = 1'b0;
  logic             stop_i = 1'b0;
  logic [RUN_W-1:0] run_rollovers_i = '0;
  logic             tag_ready_i = 1'b0;
  logic [31:0]      tag_data_i = '0;
  logic             rd_ack_i = 1'b0;
  logic             clear_o, operate_o, rd_valid_o, busy_o, done_o, overflow_o;
  logic [31:0]      rd_data_o, tag_count_o;

  int total = 0;
  int bad   = 0;
  logic [31:0] expQ[$];

  tag_acq_ctrl #(.DEPTH(DEPTH), .RUN_W(RUN_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .stop_i(stop_i),
    .run_rollovers_i(run_rollovers_i), .tag_ready_i(tag_ready_i),
    .tag_data_i(tag_data_i), .clear_o(clear_o), .operate_o(operate_o),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_ack_i(rd_ack_i),
    .busy_o(busy_o), .done_o(done_o), .overflow_o(overflow_o),
    .tag_count_o(tag_count_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic sp, input logic rdy,
                               input logic [31:0] data, input logic ack);
    start_i = st; stop_i = sp; tag_ready_i = rdy; tag_data_i = data; rd_ack_i = ack;
    cyc();
    start_i = 1'b0; stop_i = 1'b0; tag_ready_i = 1'b0; tag_data_i = '0; rd_ack_i = 1'b0;
  endtask

  task automatic feedWord(input logic [31:0] data, input bit expectCapture);
    if (expectCapture && expQ.size() < DEPTH) expQ.push_back(data);
    applyStimulus(1'b0, 1'b0, 1'b1, data, 1'b0);
  endtask

  task automatic readWord(input string tag);
    logic [31:0] exp;
    exp = expQ.pop_front();
    checkOutput({tag, "_valid"}, rd_valid_o, 1'b1);
    checkOutput(tag, rd_data_o, exp);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
  endtask

  task automatic drainAll(input string tag);
    while (expQ.size() > 0) readWord(tag);
    checkOutput({tag, "_empty"}, rd_valid_o, 1'b0);
  endtask

  task automatic waitDone(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done_o) seen = 1'b1;
      else cyc();
    end
    checkOutput({tag, "_done"}, seen, 1'b1);
    checkOutput({tag, "_idle"}, busy_o, 1'b0);
    cyc();
    checkOutput({tag, "_donePulse"}, done_o, 1'b0);
  endtask

  initial begin
    cyc();
    cyc();
    checkOutput("rst_clear", clear_o, 1'b0);
    checkOutput("rst_operate", operate_o, 1'b0);
    checkOutput("rst_rdValid", rd_valid_o, 1'b0);
    checkOutput("rst_rdData", rd_data_o, 32'd0);
    checkOutput("rst_busy", busy_o, 1'b0);
    checkOutput("rst_done", done_o, 1'b0);
    checkOutput("rst_overflow", overflow_o, 1'b0);
    checkOutput("rst_tagCount", tag_count_o, 32'd0);
    rst_ni = 1'b1;
    cyc();

    // Run limited to two rollover markers.
    run_rollovers_i = 16'd2;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("t1_armClear", clear_o, 1'b1);
    checkOutput("t1_armOperate", operate_o, 1'b0);
    checkOutput("t1_armBusy", busy_o, 1'b1);
    cyc();
    checkOutput("t1_runClear", clear_o, 1'b0);
    checkOutput("t1_runOperate", operate_o, 1'b1);
    feedWord(32'h8000_0000, 1'b1);
    checkOutput("t1_headValid", rd_valid_o, 1'b1);
    checkOutput("t1_head", rd_data_o, expQ[0]);
    checkOutput("t1_operate1", operate_o, 1'b1);
    feedWord(32'h1000_0005, 1'b1);
    checkOutput("t1_operate2", operate_o, 1'b1);
    feedWord(32'h8000_0000, 1'b1);
    checkOutput("t1_limitOperate", operate_o, 1'b0);
    checkOutput("t1_drainBusy", busy_o, 1'b1);
    drainAll("t1_read");
    waitDone("t1");
    checkOutput("t1_tagCount", tag_count_o, 32'd3);

    // Unlimited run ended by stop; a word in the first DRAIN cycle is kept.
    run_rollovers_i = 16'd0;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    cyc();
    for (int i = 1; i <= 5; i++) begin
      if (i == 3) feedWord(32'h8000_0003, 1'b1);
      else feedWord({1'b0, 4'(i), 27'(i * 1000)}, 1'b1);
    end
    checkOutput("t2_runOperate", operate_o, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    checkOutput("t2_stopOperate", operate_o, 1'b0);
    feedWord(32'h2AAA_AAAA, 1'b1);
    checkOutput("t2_tagCount", tag_count_o, 32'd6);
    drainAll("t2_read");
    waitDone("t2");

    // Overflow with no host reads.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    cyc();
    for (int i = 0; i < DEPTH + 3; i++) feedWord(32'h0100_0000 + 32'(i), 1'b1);
    checkOutput("t3_overflow", overflow_o, 1'b1);
    checkOutput("t3_tagCount", tag_count_o, 32'(DEPTH));
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    drainAll("t3_read");
    waitDone("t3");
    checkOutput("t3_sticky", overflow_o, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("t3_startOverflow", overflow_o, 1'b0);
    checkOutput("t3_startTagCount", tag_count_o, 32'd0);

    // Full FIFO with simultaneous push and pop.
    cyc();
    for (int i = 0; i < DEPTH; i++) feedWord(32'h0200_0000 + 32'(i), 1'b1);
    checkOutput("t4_fullOverflow", overflow_o, 1'b0);
    checkOutput("t4_fullHead", rd_data_o, expQ.pop_front());
    expQ.push_back(32'h7777_0001);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h7777_0001, 1'b1);
    checkOutput("t4_pushPopOverflow", overflow_o, 1'b0);
    checkOutput("t4_tagCount", tag_count_o, 32'(DEPTH + 1));
    drainAll("t4_read");
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    waitDone("t4");

    // Asynchronous reset in RUN with words buffered.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    cyc();
    for (int i = 0; i < 4; i++) feedWord(32'h0300_0000 + 32'(i), 1'b1);
    checkOutput("t5_preValid", rd_valid_o, 1'b1);
    #2 rst_ni = 1'b0;
    #1;
    checkOutput("t5_rstOperate", operate_o, 1'b0);
    checkOutput("t5_rstValid", rd_valid_o, 1'b0);
    checkOutput("t5_rstBusy", busy_o, 1'b0);
    checkOutput("t5_rstTagCount", tag_count_o, 32'd0);
    cyc();
    rst_ni = 1'b1;
    expQ.delete();
    cyc();
    run_rollovers_i = 16'd1;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("t5_armClear", clear_o, 1'b1);
    cyc();
    checkOutput("t5_runOperate", operate_o, 1'b1);
    feedWord(32'h8000_0042, 1'b1);
    checkOutput("t5_limitOperate", operate_o, 1'b0);
    drainAll("t5_read");
    waitDone("t5");
    checkOutput("t5_tagCount", tag_count_o, 32'd1);

    // Ignored controls: stop and tag_ready in IDLE, start in RUN.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    checkOutput("t6_stopIdleBusy", busy_o, 1'b0);
    checkOutput("t6_stopIdleClear", clear_o, 1'b0);
    feedWord(32'h0400_0001, 1'b0);
    checkOutput("t6_idleTagValid", rd_valid_o, 1'b0);
    checkOutput("t6_idleTagCount", tag_count_o, 32'd1);
    run_rollovers_i = 16'd0;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    checkOutput("t6_startStopClear", clear_o, 1'b1);
    checkOutput("t6_startStopTagCount", tag_count_o, 32'd0);
    cyc();
    checkOutput("t6_runOperate", operate_o, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("t6_startRunClear", clear_o, 1'b0);
    checkOutput("t6_startRunOperate", operate_o, 1'b1);
    cyc();
    checkOutput("t6_startRunClear2", clear_o, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    waitDone("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
